nibble_serial_adder: RTL
========================

// Module: nibble_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit add/subtract unit built around one 4-bit carry-lookahead slice.
//  Accepts an operand pair over a valid/ready handshake and feeds one nibble per cycle, LSB first, through the slice.
//  Registers the inter-nibble carry and returns the full result over a second valid/ready handshake.
//  Sits between the operand source and the result consumer in the datapath; reuses one small CLA instead of a WIDTH-bit adder.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; multiple of 4, >= 8. NIB = WIDTH/4.
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand pair presented
//  in_ready   out  1      unit can accept an operand pair
//  a          in   WIDTH  operand A, unsigned or two's complement
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in; used only when sub=0
//  sub        in   1      0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored)
//  out_valid  out  1      result held on sum/cout/ovf
//  out_ready  in   1      consumer takes result
//  sum        out  WIDTH  result, mod 2^WIDTH
//  cout       out  1      carry out of bit WIDTH-1 (sub: 1 = no borrow)
//  ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, nibble counter=0, carry reg=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0.
//    in_ready = (state==IDLE) & ~rst, so in_ready=0 while rst is high.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE
//    - in_ready=1.
//    - On a clock edge with in_valid & in_ready:
//      - latch a into A_r.
//      - latch sub ? ~b : b into B_r.
//      - carry reg <= sub ? 1 : cin.
//      - counter <= 0, sum <= 0, state <= RUN.
//    - a, b, cin and sub are sampled only at this edge.
//  - RUN: each cycle the slice adds A_r[4k+3:4k] + B_r[4k+3:4k] + carry reg, where k = counter.
//    - On the edge:
//      - sum[4k+3:4k] <= 4-bit slice sum.
//      - carry reg <= slice carry-out.
//      - counter++.
//    - On the edge with k = NIB-1:
//      - cout <= slice carry-out.
//      - ovf <= carry into bit 3 of the slice XOR slice carry-out.
//      - state <= DONE.
//      - out_valid <= 1.
//  - Slice carries are lookahead: g=a&b, p=a^b, c_i+1 = g_i | p_i&c_i, with c_0 = carry reg.
//    - sum_i = p_i ^ c_i for every bit, including bit 1.
//  - Latency: out_valid rises exactly NIB clock edges after the accept edge. Throughput: one operation per NIB+2 cycles minimum.
//  - DONE
//    - sum, cout, ovf and out_valid are held stable while out_ready=0, for any number of cycles.
//    - On an edge with out_valid & out_ready: out_valid <= 0, state <= IDLE.
//    - in_ready returns to 1 the next cycle; there is no accept in the same cycle as a result handoff.
//  - in_valid in RUN or DONE is ignored: no sampling, no state change.
//  - sum/cout/ovf keep their last value after handoff until the next accept clears sum.
//  - Reset mid-RUN or mid-DONE aborts the operation. All outputs take reset values immediately (async); no partial result is ever flagged valid.
//  - Wrap-around: carry out of the top nibble is reported on cout only. It is never fed back and never affects sum.
//  - busy = (state != IDLE).
// TESTING  (WIDTH=16 unless noted)
//  1. a=0x1234, b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, ovf=0; out_valid exactly 4 edges after accept.
//  2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry crosses all 4 nibbles); a=0x000F, b=0x0000, cin=1 -> sum=0x0010.
//  3. sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1; cin=1 must not change either result.
//  4. Backpressure: hold out_ready=0 for 6 cycles after out_valid with in_valid=1 and changing a/b -> sum/cout/ovf stable, in_ready=0, no new accept; out_ready=1 -> handoff, in_ready=1 next cycle.
//  5. Assert rst for 1 cycle in RUN after 2 nibbles -> out_valid=0, sum=0, in_ready=1 after release; next operation 0x7FFF+0x0001 gives sum=0x8000, ovf=1.
//  6. WIDTH=32 random a/b/cin/sub (>=1000 ops, random in_valid/out_ready) vs reference model -> all results match; latency always 8.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit add/subtract unit that reuses a single 4-bit
//   carry-lookahead slice. An operand pair is accepted over in_valid/in_ready.
//   One nibble per cycle (LSB first) is added, with the inter-nibble carry
//   kept in a register. The result is then offered over out_valid/out_ready.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready  operand handshake; a, b, cin, sub sampled on accept
//   a, b               WIDTH-bit operands
//   cin                carry-in (add only), sub: 1 = a - b
//   out_valid/out_ready result handshake
//   sum, cout, ovf     result, carry out of MSB, signed overflow
//   busy               operation in flight (RUN or DONE)
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, cout_q, ovf_q, ovld_q;

  logic             accept, handoff, last;
  logic [3:0]       a_nib, b_nib, g, p, s_sum;
  logic [4:0]       c;

  assign accept  = in_valid & in_ready;
  assign handoff = ovld_q & out_ready;
  assign last    = (cnt_q == CW'(NIB - 1));

  // Nibble select for the current counter value.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIB; n++) begin
      if (cnt_q == CW'(n)) begin
        a_nib = a_q[4*n +: 4];
        b_nib = b_q[4*n +: 4];
      end
    end
  end

  // 4-bit carry-lookahead slice: every carry is a flat function of g/p/c0.
  assign g    = a_nib & b_nib;
  assign p    = a_nib ^ b_nib;
  assign c[0] = c_q;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign s_sum = p ^ c[3:0];

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)  state_d = S_RUN;
      S_RUN:   if (last)    state_d = S_DONE;
      S_DONE:  if (handoff) state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. in_ready is gated by rst so nothing is offered during reset.
  always_comb begin
    in_ready = (state_q == S_IDLE) & ~rst;
    busy     = (state_q != S_IDLE);
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cnt_q  <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      ovld_q <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= sub ? ~b : b;
      c_q   <= sub | cin;   // subtract is a + ~b + 1; cin ignored
      cnt_q <= '0;
      sum_q <= '0;
    end else if (state_q == S_RUN) begin
      for (int n = 0; n < NIB; n++) begin
        if (cnt_q == CW'(n)) sum_q[4*n +: 4] <= s_sum;
      end
      c_q   <= c[4];
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        cout_q <= c[4];
        ovf_q  <= c[3] ^ c[4];
        ovld_q <= 1'b1;
      end
    end else if (handoff) begin
      ovld_q <= 1'b0;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = ovld_q;

endmodule
